// File: rtl/wb_pkg.sv
// Shared write-back definitions: result-source encodings and the pending-write entry layout.
package wb_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;
  localparam logic [1:0] WB_SEL_ILL  = 2'b11;

  localparam int WB_DATA_W = 16;
  localparam int WB_DEST_W = 3;

  typedef struct packed {
    logic [WB_DEST_W-1:0] dest;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order pending-write queue with per-slot valid bits and an oldest-to-youngest view of all slots.
module wb_fifo #(
  parameter  int DEPTH   = 2,
  parameter  int ENTRY_W = 19,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ENTRY_W-1:0]       push_entry,
  output logic [ENTRY_W-1:0]       head_entry,
  output logic [CNT_W-1:0]         count,
  output logic                     full,
  output logic                     empty,
  output logic [DEPTH-1:0]         ent_vld,
  output logic [DEPTH*ENTRY_W-1:0] ent_flat
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]   slot_vld;
  logic [DEPTH-1:0]   slot_vld_nxt;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   idx;

  // Clear before set: a full-queue push+pop reuses the slot being retired.
  always_comb begin
    slot_vld_nxt = slot_vld;
    if (pop)  slot_vld_nxt[rd_ptr] = 1'b0;
    if (push) slot_vld_nxt[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      slot_vld <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      slot_vld <= slot_vld_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign head_entry = mem[rd_ptr];

  // Slot i of the view is i entries behind the head, so higher i is younger.
  always_comb begin
    idx      = '0;
    ent_vld  = '0;
    ent_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx                            = rd_ptr + PTR_W'(i);
      ent_vld[i]                     = slot_vld[idx];
      ent_flat[i*ENTRY_W +: ENTRY_W] = mem[idx];
    end
  end

endmodule

// File: rtl/wb_stage_buf.sv
// Write-back stage: result select, queued register-file writes with grant-based drain, forwarding lookup.
// Optional macro ZERO_REG_EN: register 0 is hardwired (never queued, never forwarded).
module wb_stage_buf
  import wb_pkg::*;
#(
  parameter  int DATA_W = WB_DATA_W,
  parameter  int DEST_W = WB_DEST_W,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wr_en,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [1:0]        in_sel,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [DATA_W-1:0] in_link,
  output logic              writ_en,
  output logic [DEST_W-1:0] writ_dest,
  output logic [DATA_W-1:0] writ_data,
  input  logic              writ_gnt,
  output logic [DEST_W-1:0] wb_op_dest,
  output logic              wb_op_valid,
  input  logic [DEST_W-1:0] fwd_dest,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  occupancy,
  output logic              sel_err
);

  localparam int ENTRY_W = DEST_W + DATA_W;

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic logic [DATA_W-1:0] sel_result(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] mem,
    input logic [DATA_W-1:0] link
  );
    case (sel)
      WB_SEL_ALU:  return alu;
      WB_SEL_MEM:  return mem;
      WB_SEL_LINK: return link;
      default:     return '0;
    endcase
  endfunction

  logic                     accept;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic                     dest_live;
  logic                     fwd_q_ok;
  entry_t                   push_entry;
  entry_t                   head_entry;
  entry_t                   slot;
  logic [DEPTH-1:0]         ent_vld;
  logic [DEPTH*ENTRY_W-1:0] ent_flat;

`ifdef ZERO_REG_EN
  assign dest_live = (in_dest != '0);
  assign fwd_q_ok  = (fwd_dest != '0);
`else
  assign dest_live = 1'b1;
  assign fwd_q_ok  = 1'b1;
`endif

  assign writ_en         = ~empty;
  assign pop             = writ_en & writ_gnt;
  assign in_ready        = ~full | pop;
  assign accept          = in_valid & in_ready;
  assign push            = accept & in_wr_en & dest_live;
  assign push_entry.dest = in_dest;
  assign push_entry.data = sel_result(in_sel, in_alu, in_mem, in_link);

  wb_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .count      (occupancy),
    .full       (full),
    .empty      (empty),
    .ent_vld    (ent_vld),
    .ent_flat   (ent_flat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              sel_err <= 1'b0;
    else if (accept && in_sel == WB_SEL_ILL) sel_err <= 1'b1;
  end

  // Storage is not reset, so head fields are forced to 0 while the queue is empty.
  assign writ_dest   = writ_en ? head_entry.dest : '0;
  assign writ_data   = writ_en ? head_entry.data : '0;
  assign wb_op_dest  = writ_dest;
  assign wb_op_valid = writ_en;

  // Scan oldest to youngest so the last match (youngest) overrides.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    if (fwd_q_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot = entry_t'(ent_flat[i*ENTRY_W +: ENTRY_W]);
        if (ent_vld[i] && slot.dest == fwd_dest) begin
          fwd_hit  = 1'b1;
          fwd_data = slot.data;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_buf.sv
// Directed bench for wb_stage_buf: vector table plus hand-written reset-under-traffic sequence.
module tb_wb_stage_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_wr_en;
  logic [2:0]  in_dest;
  logic [1:0]  in_sel;
  logic [15:0] in_alu, in_mem, in_link;
  logic        writ_en, writ_gnt;
  logic [2:0]  writ_dest;
  logic [15:0] writ_data;
  logic [2:0]  wb_op_dest;
  logic        wb_op_valid;
  logic [2:0]  fwd_dest;
  logic        fwd_hit;
  logic [15:0] fwd_data;
  logic [1:0]  occupancy;
  logic        sel_err;

  int n_chk  = 0;
  int n_fail = 0;

  wb_stage_buf #(.DATA_W(16), .DEST_W(3), .DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_wr_en    (in_wr_en),
    .in_dest     (in_dest),
    .in_sel      (in_sel),
    .in_alu      (in_alu),
    .in_mem      (in_mem),
    .in_link     (in_link),
    .writ_en     (writ_en),
    .writ_dest   (writ_dest),
    .writ_data   (writ_data),
    .writ_gnt    (writ_gnt),
    .wb_op_dest  (wb_op_dest),
    .wb_op_valid (wb_op_valid),
    .fwd_dest    (fwd_dest),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data),
    .occupancy   (occupancy),
    .sel_err     (sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic        wr;
    logic [2:0]  dest;
    logic [1:0]  sel;
    logic [15:0] alu;
    logic [15:0] mem;
    logic [15:0] link;
    logic        gnt;
    logic [2:0]  fd;
    logic        e_rdy;
    logic [1:0]  e_occ;
    logic        e_wen;
    logic [2:0]  e_wdest;
    logic [15:0] e_wdata;
    logic        e_hit;
    logic [15:0] e_fdata;
    logic        e_serr;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic vld, input logic wr, input logic [2:0] dest, input logic [1:0] sel,
    input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] link,
    input logic gnt, input logic [2:0] fd,
    input logic e_rdy, input logic [1:0] e_occ, input logic e_wen, input logic [2:0] e_wdest,
    input logic [15:0] e_wdata, input logic e_hit, input logic [15:0] e_fdata, input logic e_serr
  );
    vec_t v;
    v.vld = vld; v.wr = wr; v.dest = dest; v.sel = sel;
    v.alu = alu; v.mem = mem; v.link = link; v.gnt = gnt; v.fd = fd;
    v.e_rdy = e_rdy; v.e_occ = e_occ; v.e_wen = e_wen; v.e_wdest = e_wdest;
    v.e_wdata = e_wdata; v.e_hit = e_hit; v.e_fdata = e_fdata; v.e_serr = e_serr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = v.vld; in_wr_en = v.wr; in_dest = v.dest; in_sel = v.sel;
    in_alu = v.alu; in_mem = v.mem; in_link = v.link; writ_gnt = v.gnt; fwd_dest = v.fd;
  endtask

  task automatic idle();
    in_valid = 0; in_wr_en = 0; in_dest = 0; in_sel = 0;
    in_alu = 0; in_mem = 0; in_link = 0; writ_gnt = 0; fwd_dest = 0;
  endtask

  initial begin
    // vld wr dest sel alu mem link gnt fd | rdy occ wen wdest wdata hit fdata serr
    vecs[0]  = mk(1,1,3'd1,2'b00,16'h0011,16'hDEAD,16'hBEEF,1,3'd1, 1,2'd1,1,3'd1,16'h0011,1,16'h0011,0);
    vecs[1]  = mk(1,1,3'd2,2'b01,16'h0999,16'h0022,16'hBEEF,1,3'd1, 1,2'd1,1,3'd2,16'h0022,0,16'h0000,0);
    vecs[2]  = mk(1,1,3'd3,2'b10,16'h0999,16'h0888,16'h0033,1,3'd3, 1,2'd1,1,3'd3,16'h0033,1,16'h0033,0);
    vecs[3]  = mk(0,0,3'd0,2'b00,16'h0000,16'h0000,16'h0000,1,3'd3, 1,2'd0,0,3'd0,16'h0000,0,16'h0000,0);
    vecs[4]  = mk(1,1,3'd4,2'b00,16'h1111,16'h0000,16'h0000,0,3'd4, 1,2'd1,1,3'd4,16'h1111,1,16'h1111,0);
    vecs[5]  = mk(1,1,3'd4,2'b00,16'h2222,16'h0000,16'h0000,0,3'd4, 1,2'd2,1,3'd4,16'h1111,1,16'h2222,0);
    vecs[6]  = mk(1,1,3'd5,2'b00,16'h5555,16'h0000,16'h0000,0,3'd5, 0,2'd2,1,3'd4,16'h1111,0,16'h0000,0);
    vecs[7]  = mk(1,1,3'd5,2'b00,16'h5555,16'h0000,16'h0000,1,3'd4, 1,2'd2,1,3'd4,16'h2222,1,16'h2222,0);
    vecs[8]  = mk(1,0,3'd7,2'b00,16'h7777,16'h0000,16'h0000,1,3'd5, 1,2'd1,1,3'd5,16'h5555,1,16'h5555,0);
    vecs[9]  = mk(0,0,3'd0,2'b00,16'h0000,16'h0000,16'h0000,1,3'd5, 1,2'd0,0,3'd0,16'h0000,0,16'h0000,0);
    vecs[10] = mk(1,1,3'd6,2'b11,16'h6666,16'h6667,16'h6668,0,3'd6, 1,2'd1,1,3'd6,16'h0000,1,16'h0000,1);
    vecs[11] = mk(0,0,3'd0,2'b00,16'h0000,16'h0000,16'h0000,1,3'd6, 1,2'd0,0,3'd0,16'h0000,0,16'h0000,1);
    vecs[12] = mk(1,0,3'd2,2'b00,16'h1234,16'h0000,16'h0000,0,3'd2, 1,2'd0,0,3'd0,16'h0000,0,16'h0000,1);
`ifdef ZERO_REG_EN
    vecs[13] = mk(1,1,3'd0,2'b00,16'hBEEF,16'h0000,16'h0000,0,3'd0, 1,2'd0,0,3'd0,16'h0000,0,16'h0000,1);
`else
    vecs[13] = mk(1,1,3'd0,2'b00,16'hBEEF,16'h0000,16'h0000,0,3'd0, 1,2'd1,1,3'd0,16'hBEEF,1,16'hBEEF,1);
`endif
    vecs[14] = mk(0,0,3'd0,2'b00,16'h0000,16'h0000,16'h0000,1,3'd0, 1,2'd0,0,3'd0,16'h0000,0,16'h0000,1);

    idle();
    rst_n = 1'b0;
    #2;
    chk("rst_occ",   32'(occupancy), 32'd0);
    chk("rst_wen",   32'(writ_en),   32'd0);
    chk("rst_rdy",   32'(in_ready),  32'd1);
    chk("rst_serr",  32'(sel_err),   32'd0);
    chk("rst_wdata", 32'(writ_data), 32'd0);
    chk("rst_hit",   32'(fwd_hit),   32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_occupancy", i), 32'(occupancy),  32'(vecs[i].e_occ));
      chk($sformatf("v%0d_writ_en", i),   32'(writ_en),    32'(vecs[i].e_wen));
      chk($sformatf("v%0d_op_valid", i),  32'(wb_op_valid), 32'(vecs[i].e_wen));
      chk($sformatf("v%0d_writ_dest", i), 32'(writ_dest),  32'(vecs[i].e_wdest));
      chk($sformatf("v%0d_op_dest", i),   32'(wb_op_dest), 32'(vecs[i].e_wdest));
      chk($sformatf("v%0d_writ_data", i), 32'(writ_data),  32'(vecs[i].e_wdata));
      chk($sformatf("v%0d_fwd_hit", i),   32'(fwd_hit),    32'(vecs[i].e_hit));
      chk($sformatf("v%0d_fwd_data", i),  32'(fwd_data),   32'(vecs[i].e_fdata));
      chk($sformatf("v%0d_sel_err", i),   32'(sel_err),    32'(vecs[i].e_serr));
    end

    // Reset asserted mid-traffic with two writes pending and sel_err set.
    in_valid = 1; in_wr_en = 1; in_dest = 3'd1; in_sel = 2'b00; in_alu = 16'hAAAA; writ_gnt = 0;
    fwd_dest = 3'd1;
    @(posedge clk); #1;
    in_dest = 3'd2; in_alu = 16'hBBBB;
    @(posedge clk); #1;
    chk("pre_rst_occ",  32'(occupancy), 32'd2);
    chk("pre_rst_rdy",  32'(in_ready),  32'd0);
    chk("pre_rst_serr", 32'(sel_err),   32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_occ",  32'(occupancy), 32'd0);
    chk("mid_rst_wen",  32'(writ_en),   32'd0);
    chk("mid_rst_rdy",  32'(in_ready),  32'd1);
    chk("mid_rst_serr", 32'(sel_err),   32'd0);
    chk("mid_rst_hit",  32'(fwd_hit),   32'd0);
    chk("mid_rst_dest", 32'(writ_dest), 32'd0);
    idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_occ", 32'(occupancy), 32'd0);
    chk("post_rst_wen", 32'(writ_en),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
